// File: rtl/pkt_inject_nic.sv
// pkt_inject_nic: PE-side network interface. Encodes PE send requests into
// XY-routing packets, queues them in a small FIFO and presents them one at a
// time to the router's PE input port.
//
// Handshakes:
//   PE side:     a request is taken on any rising edge where pe_valid && pe_ready.
//                pe_ready is simply !fifo_full.
//   Router side: out_req/out_data are a registered offer. They stay stable until
//                a rising edge with out_gnt high consumes the packet.
module pkt_inject_nic #(
  parameter int          DATA_WIDTH      = 64,
  parameter logic [15:0] CURRENT_ADDRESS = 16'h0000,
  parameter int          FIFO_DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pe_valid,
  output logic                  pe_ready,
  input  logic [15:0]           pe_dest,
  input  logic [31:0]           pe_payload,
  output logic                  out_req,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_gnt,
  output logic                  err,
  output logic [15:0]           sent_count,
  output logic [0:0]            dbg_state
);

  localparam int          AW    = $clog2(FIFO_DEPTH);
  localparam logic [7:0]  CUR_X = CURRENT_ADDRESS[15:8];
  localparam logic [7:0]  CUR_Y = CURRENT_ADDRESS[7:0];

  localparam logic [0:0]  IDLE  = 1'b0;
  localparam logic [0:0]  SEND  = 1'b1;

  logic [0:0]            state;
  logic                  vc;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wptr;
  logic [AW-1:0]         rptr;
  logic [AW:0]           count;
  logic                  fifo_full;
  logic                  fifo_empty;

  logic [8:0]            dx;
  logic [8:0]            dy;
  logic [8:0]            abs_dx;
  logic [8:0]            abs_dy;
  logic                  dir_x;
  logic                  dir_y;
  logic                  hop_ovf;
  logic [63:0]           enc64;
  logic [DATA_WIDTH-1:0] enc;

  logic                  accept;
  logic                  push;
  logic                  pop;

  assign fifo_full  = (count == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign pe_ready   = !fifo_full;

  // Two's-complement offsets in 9 bits so the full 8-bit coordinate range fits.
  assign dx      = {1'b0, pe_dest[15:8]} - {1'b0, CUR_X};
  assign dy      = {1'b0, pe_dest[7:0]}  - {1'b0, CUR_Y};
  assign abs_dx  = dx[8] ? (9'd0 - dx) : dx;
  assign abs_dy  = dy[8] ? (9'd0 - dy) : dy;
  assign dir_x   = (pe_dest[15:8] >= CUR_X);
  assign dir_y   = (pe_dest[7:0]  >= CUR_Y);
  // Hop fields are 4 bits; anything farther cannot be encoded and is dropped.
  assign hop_ovf = (abs_dx > 9'd15) || (abs_dy > 9'd15);

  assign enc64 = {vc, dir_x, dir_y, 5'b00000, abs_dx[3:0], abs_dy[3:0],
                  CUR_X, CUR_Y, pe_payload};
  assign enc   = DATA_WIDTH'(enc64);

  assign accept = pe_valid && pe_ready;
  assign push   = accept && !hop_ovf;
  // Head leaves the FIFO whenever the output register is free or being granted.
  assign pop    = !fifo_empty && ((state == IDLE) || out_gnt);

  assign out_req   = (state == SEND);
  assign dbg_state = state;

  // FIFO storage: written on every enqueue, no reset needed on the array.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= enc;
  end

  // FIFO pointers/count, vc toggling and overflow error pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      vc    <= 1'b0;
      err   <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (push) vc <= !vc;
      err <= accept && hop_ovf;
    end
  end

  // Output FSM: IDLE waits for a queued packet, SEND holds it until granted.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      out_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            out_data <= mem[rptr];
            state    <= SEND;
          end
        end
        SEND: begin
          if (out_gnt) begin
            if (!fifo_empty) out_data <= mem[rptr];
            else             state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Count packets actually consumed by the router.
  always_ff @(posedge clk) begin
    if (reset)                  sent_count <= '0;
    else if (out_req && out_gnt) sent_count <= sent_count + 16'd1;
  end

endmodule

// File: tb/tb_pkt_inject_nic.sv
// Testbench for pkt_inject_nic at node (2,2): directed scenarios followed by
// random traffic, all checked each cycle against a queue-based reference model.
module tb_pkt_inject_nic;

  localparam int          DW    = 64;
  localparam int          DEPTH = 4;
  localparam logic [15:0] CUR   = 16'h0202;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          pe_valid;
  logic          pe_ready;
  logic [15:0]   pe_dest;
  logic [31:0]   pe_payload;
  logic          out_req;
  logic [DW-1:0] out_data;
  logic          out_gnt;
  logic          err;
  logic [15:0]   sent_count;
  logic [0:0]    dbg_state;

  pkt_inject_nic #(
    .DATA_WIDTH(DW), .CURRENT_ADDRESS(CUR), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .pe_valid(pe_valid), .pe_ready(pe_ready),
    .pe_dest(pe_dest), .pe_payload(pe_payload),
    .out_req(out_req), .out_data(out_data), .out_gnt(out_gnt),
    .err(err), .sent_count(sent_count), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard / reference model ----------------
  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_q[$];
  logic          m_slot_valid;
  logic [DW-1:0] m_slot_data;
  logic          m_vc;
  logic          m_err;
  logic [15:0]   m_sent;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_slot_valid = 1'b0;
    m_slot_data  = '0;
    m_vc         = 1'b0;
    m_err        = 1'b0;
    m_sent       = '0;
  endtask

  // Advance the model across one rising edge with the given inputs.
  task automatic model_step(input logic v, input logic [15:0] dest,
                            input logic [31:0] pl, input logic gnt, input logic rst);
    int dxi, dyi, ax, ay;
    logic accept, grant;
    logic [7:0] cx, cy;
    if (rst) begin
      model_reset();
      return;
    end
    cx     = CUR[15:8];
    cy     = CUR[7:0];
    accept = v && (exp_q.size() < DEPTH);
    grant  = m_slot_valid && gnt;
    if (grant) m_sent = m_sent + 16'd1;
    if ((!m_slot_valid || grant) && exp_q.size() > 0) begin
      m_slot_data  = exp_q.pop_front();
      m_slot_valid = 1'b1;
    end else if (grant) begin
      m_slot_valid = 1'b0;
    end
    m_err = 1'b0;
    if (accept) begin
      dxi = int'(dest[15:8]) - int'(cx);
      dyi = int'(dest[7:0])  - int'(cy);
      ax  = iabs(dxi);
      ay  = iabs(dyi);
      if (ax > 15 || ay > 15) begin
        m_err = 1'b1;
      end else begin
        exp_q.push_back({m_vc, (dxi >= 0), (dyi >= 0), 5'b0, 4'(ax), 4'(ay),
                         cx, cy, pl});
        m_vc = !m_vc;
      end
    end
  endtask

  task automatic check_model();
    check("out_req", 64'(out_req), 64'(m_slot_valid));
    if (m_slot_valid) check("out_data", out_data, m_slot_data);
    check("pe_ready", 64'(pe_ready), 64'(exp_q.size() < DEPTH));
    check("err", 64'(err), 64'(m_err));
    check("sent_count", 64'(sent_count), 64'(m_sent));
  endtask

  // ---------------- driver ----------------
  // Drive one cycle of inputs, step the model, then check at the falling edge.
  task automatic cycle(input logic v, input logic [15:0] dest, input logic [31:0] pl,
                       input logic gnt, input logic rst);
    pe_valid   = v;
    pe_dest    = dest;
    pe_payload = pl;
    out_gnt    = gnt;
    reset      = rst;
    model_step(v, dest, pl, gnt, rst);
    @(negedge clk);
    check_model();
  endtask

  task automatic idle(input logic gnt);
    cycle(1'b0, 16'h0000, 32'h0, gnt, 1'b0);
  endtask

  int grants;

  initial begin
    pe_valid = 0; pe_dest = 0; pe_payload = 0; out_gnt = 0; reset = 1;
    model_reset();
    @(negedge clk);
    cycle(1'b0, 16'h0, 32'h0, 1'b0, 1'b1);
    check("rst_out_data", out_data, 64'h0);
    check("rst_pe_ready", 64'(pe_ready), 64'h1);

    // Right/down, 2-cycle latency, one grant
    cycle(1'b1, 16'h0500, 32'hDEADBEEF, 1'b1, 1'b0);
    check("lat_req_low", 64'(out_req), 64'h0);
    idle(1'b1);
    check("rd_req", 64'(out_req), 64'h1);
    check("rd_data", out_data, 64'h4032_0202_DEAD_BEEF);
    idle(1'b1);
    check("rd_sent", 64'(sent_count), 64'h1);

    // Left/up, vc now 1
    cycle(1'b1, 16'h0005, 32'h1, 1'b1, 1'b0);
    idle(1'b1);
    check("lu_data", out_data, 64'hA023_0202_0000_0001);
    idle(1'b1);

    // Self-addressed, vc back to 0
    cycle(1'b1, 16'h0202, 32'h55, 1'b1, 1'b0);
    idle(1'b1);
    check("self_hdr", 64'(out_data[63:48]), 64'h6000);
    idle(1'b1);

    // Hop overflow: dropped, err pulses once, vc unchanged (stays 1)
    cycle(1'b1, 16'h1402, 32'h77, 1'b1, 1'b0);
    check("ovf_err", 64'(err), 64'h1);
    check("ovf_noreq", 64'(out_req), 64'h0);
    idle(1'b1);
    check("ovf_err_clr", 64'(err), 64'h0);
    check("ovf_noreq2", 64'(out_req), 64'h0);
    cycle(1'b1, 16'h0203, 32'h88, 1'b1, 1'b0);
    idle(1'b1);
    check("ovf_vc", 64'(out_data[63]), 64'h1);
    idle(1'b1);
    idle(1'b0);

    // Backpressure: 5 requests, no grant
    for (int i = 0; i < 5; i++) cycle(1'b1, 16'h0303, 32'(i), 1'b0, 1'b0);
    check("bp_full", 64'(pe_ready), 64'h0);
    check("bp_req", 64'(out_req), 64'h1);
    cycle(1'b1, 16'h0303, 32'h99, 1'b0, 1'b0);
    grants = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_req) grants++;
      idle(1'b1);
    end
    check("bp_grants", 64'(grants), 64'd5);
    check("bp_drained", 64'(out_req), 64'h0);

    // Reset mid-transfer: 1 held + 3 queued
    for (int i = 0; i < 4; i++) cycle(1'b1, 16'h0101, 32'(i), 1'b0, 1'b0);
    check("mid_req", 64'(out_req), 64'h1);
    cycle(1'b0, 16'h0, 32'h0, 1'b1, 1'b1);
    check("mid_rst_req", 64'(out_req), 64'h0);
    check("mid_rst_sent", 64'(sent_count), 64'h0);
    check("mid_rst_ready", 64'(pe_ready), 64'h1);
    idle(1'b1);
    check("mid_rst_empty", 64'(out_req), 64'h0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] d;
      d[15:8] = 8'($urandom_range(0, 20));
      d[7:0]  = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255))
                                             : 8'($urandom_range(0, 18));
      cycle(($urandom_range(0, 9) < 6), d, $urandom, ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 199) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pkt_inject_nic.md
PKT_INJECT_NIC -- requirements
Module: pkt_inject_nic

Interface
REQ-001 Parameter DATA_WIDTH, default 64: packet width.
REQ-002 Parameter CURRENT_ADDRESS, default 16'h0000: local node address, x in [15:8], y in [7:0].
REQ-003 Parameter FIFO_DEPTH, default 4: encoded-packet queue depth, power of two.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 pe_valid  input  1  PE offers a send request.
REQ-007 pe_ready  output  1  NIC accepts the request this cycle.
REQ-008 pe_dest  input  16  destination address, x [15:8], y [7:0].
REQ-009 pe_payload  input  32  packet payload.
REQ-010 out_req  output  1  packet valid toward router PE input port.
REQ-011 out_data  output  DATA_WIDTH  encoded packet.
REQ-012 out_gnt  input  1  router consumes out_data this cycle.
REQ-013 err  output  1  one-cycle pulse: request dropped for hop overflow.
REQ-014 sent_count  output  16  packets granted since reset.

Function
REQ-015 The block SHALL accept a request when pe_valid && pe_ready; pe_ready SHALL equal !fifo_full.
REQ-016 The block SHALL encode on acceptance, with dx = dest_x - CURRENT_x and dy = dest_y - CURRENT_y as signed 9-bit values.
REQ-017 The encoding SHALL set bit 63 = vc flop; bit 62 dir_x = (dest_x >= CURRENT_x); bit 61 dir_y = (dest_y >= CURRENT_y); bits 60:56 = 0.
REQ-018 The encoding SHALL set bits 55:52 hop_x = |dx| and bits 51:48 hop_y = |dy|.
REQ-019 The encoding SHALL set bits 47:40 = CURRENT_x, bits 39:32 = CURRENT_y, and bits 31:0 = pe_payload.
REQ-020 dest == CURRENT_ADDRESS SHALL be legal, encoding dir_x = dir_y = 1 and hop = 0.
REQ-021 If |dx| > 15 or |dy| > 15, the request SHALL still be handshaken but SHALL NOT be enqueued; err SHALL be 1 on the following cycle only; vc SHALL NOT toggle.
REQ-022 vc SHALL toggle on every enqueued packet.
REQ-023 The FIFO SHALL use wrapping read/write pointers with a count of width log2(FIFO_DEPTH)+1.
REQ-024 On a full FIFO, pe_ready SHALL be 0; a simultaneous pop SHALL NOT enable a push in the same cycle.
REQ-025 The FSM SHALL have two states, IDLE and SEND; out_req SHALL be 1 if and only if state == SEND.
REQ-026 IDLE with FIFO non-empty: load out_data from head, pop, go to SEND.
REQ-027 SEND with !out_gnt: hold out_data and out_req unchanged.
REQ-028 SEND with out_gnt and FIFO non-empty: load next head, pop, stay in SEND, giving back-to-back packets with no bubble.
REQ-029 SEND with out_gnt and FIFO empty: go to IDLE.
REQ-030 sent_count SHALL increment on each cycle with out_req && out_gnt, wrapping at 16'hFFFF to 0.
REQ-031 Latency SHALL be: a request accepted at edge N with an empty FIFO in IDLE drives out_req high after edge N+1.
REQ-032 out_gnt while in IDLE SHALL be ignored.
REQ-033 A simultaneous enqueue and pop on a non-full FIFO SHALL leave the count unchanged.

Reset
REQ-034 reset SHALL set: state IDLE, FIFO empty (pointers and count 0), vc 0, out_req 0, out_data 0, err 0, sent_count 0; pe_ready is therefore 1 in the cycle after reset.
REQ-035 reset mid-transfer SHALL discard the held packet and all queued packets with no grant counted; reset SHALL take priority over all other inputs.

Verification (CURRENT_ADDRESS = 16'h0202)
REQ-036 Right/down: pe_dest 16'h0500, payload 32'hDEADBEEF, out_gnt = 1 -> out_req high 2 cycles later, out_data = 64'h4032_0202_DEAD_BEEF, sent_count = 1.
REQ-037 Left/up with vc toggle: after one packet sent, pe_dest 16'h0005, payload 32'h1 -> out_data = 64'hA023_0202_0000_0001.
REQ-038 Backpressure: out_gnt = 0 with 5 requests -> one packet held on out_req, 4 queued, pe_ready = 0 on the sixth offer; then out_gnt = 1 -> 5 consecutive grants with no bubble.
REQ-039 Overflow: pe_dest 16'h1402 (dx = 18) -> handshake completes, err pulses 1 cycle, no out_req, vc unchanged.
REQ-040 Self: pe_dest 16'h0202 -> out_data[63:48] = 16'h6000 (vc 0).
REQ-041 Reset while out_req is high with 3 queued -> next cycle out_req = 0, FIFO empty, sent_count = 0, pe_ready = 1.
